// File: rtl/oam_scan_writer.sv
// Mode-2 OAM scanner: walks every OAM entry's Y byte against the current line
// and writes up to N_SLOTS hits, in ascending OAM order, into the sprite store.
module oam_scan_writer #(
  parameter int N_SLOTS   = 10,
  parameter int N_ENTRIES = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scan_start,
  input  logic [7:0]         ly,
  input  logic               obj_tall,
  output logic [7:0]         oam_addr,
  output logic               oam_rd,
  input  logic [7:0]         oam_y,
  output logic [N_SLOTS-1:0] store_we,
  output logic [5:0]         store_idx,
  output logic [3:0]         store_line,
  output logic [3:0]         sprite_count,
  output logic               scan_busy,
  output logic               scan_done
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    CMP,
    DONE
  } state_t;

  localparam logic [5:0] LAST_ENTRY = 6'(N_ENTRIES - 1);
  localparam logic [3:0] SLOT_CAP   = 4'(N_SLOTS);

  state_t      state;
  logic [5:0]  entry;
  logic [7:0]  ly_q;

  logic [8:0]         diff;
  logic [8:0]         height;
  logic               hit;
  logic               room;
  logic [N_SLOTS-1:0] slot_sel;

  // Screen Y is OAM Y minus 16; the 9th bit catches sprites that start below ly.
  always_comb begin
    diff     = {1'b0, ly_q} + 9'd16 - {1'b0, oam_y};
    height   = obj_tall ? 9'd16 : 9'd8;
    hit      = !diff[8] && (diff < height);
    room     = sprite_count < SLOT_CAP;
    slot_sel = {{(N_SLOTS-1){1'b0}}, 1'b1} << sprite_count;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      entry        <= '0;
      ly_q         <= '0;
      sprite_count <= '0;
      store_we     <= '0;
      store_idx    <= '0;
      store_line   <= '0;
      oam_addr     <= '0;
      oam_rd       <= 1'b0;
      scan_busy    <= 1'b0;
      scan_done    <= 1'b0;
    end else begin
      store_we  <= '0;
      scan_done <= 1'b0;
      // A start pulse wins in every state, so a hit being compared now is dropped.
      if (scan_start) begin
        state        <= ADDR;
        ly_q         <= ly;
        entry        <= '0;
        sprite_count <= '0;
        oam_addr     <= '0;
        oam_rd       <= 1'b1;
        scan_busy    <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            oam_rd <= 1'b0;
            state  <= CMP;
          end
          CMP: begin
            if (hit && room) begin
              store_we     <= slot_sel;
              store_idx    <= entry;
              store_line   <= diff[3:0];
              sprite_count <= sprite_count + 4'd1;
            end
            if (entry == LAST_ENTRY) begin
              state     <= DONE;
              scan_busy <= 1'b0;
              scan_done <= 1'b1;
            end else begin
              entry    <= entry + 6'd1;
              state    <= ADDR;
              oam_addr <= {entry + 6'd1, 2'b00};
              oam_rd   <= 1'b1;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
